// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator for the decode stage.
// The immediate is decoded combinationally from the incoming instruction and
// captured into a two-entry elastic buffer (main + skid). The buffer has
// valid/ready handshakes on both sides, and a side-band tag travels with
// each entry.
module imm_gen_pipe #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned TAG_WIDTH   = 32,
  localparam int unsigned TYPE_W     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   Flush,
  input  logic                   In_Valid,
  output logic                   In_Ready,
  input  logic [INSTR_WIDTH-1:0] Instr,
  input  logic [TYPE_W-1:0]      Imm_Type,
  input  logic [TAG_WIDTH-1:0]   In_Tag,
  output logic                   Out_Valid,
  input  logic                   Out_Ready,
  output logic [XLEN-1:0]        Imm,
  output logic                   Imm_Err,
  output logic [TYPE_W-1:0]      Out_Type,
  output logic [TAG_WIDTH-1:0]   Out_Tag
);

  // Immediate format encodings carried on Imm_Type
  localparam logic [TYPE_W-1:0] T_NONE  = 3'd0;
  localparam logic [TYPE_W-1:0] T_I     = 3'd1;
  localparam logic [TYPE_W-1:0] T_S     = 3'd2;
  localparam logic [TYPE_W-1:0] T_B     = 3'd3;
  localparam logic [TYPE_W-1:0] T_U     = 3'd4;
  localparam logic [TYPE_W-1:0] T_J     = 3'd5;
  localparam logic [TYPE_W-1:0] T_Z     = 3'd6;
  localparam logic [TYPE_W-1:0] T_SHAMT = 3'd7;

  // One buffered entry: everything the output side presents
  typedef struct packed {
    logic [XLEN-1:0]      imm;
    logic                 err;
    logic [TYPE_W-1:0]    typ;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  logic [XLEN-1:0] imm_c;
  logic            err_c;
  entry_t          new_c;

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;

  logic   accept_c;
  logic   drain_c;

  // Opcode and any bits above 32 carry no immediate information
  logic unused_instr;
  assign unused_instr = ^Instr;

  // Decode the immediate for the presented instruction
  always_comb begin
    imm_c = '0;
    err_c = 1'b0;
    case (Imm_Type)
      T_NONE: imm_c = '0;
      T_I:    imm_c = XLEN'($signed(Instr[31:20]));
      T_S:    imm_c = XLEN'($signed({Instr[31:25], Instr[11:7]}));
      T_B:    imm_c = XLEN'($signed({Instr[31], Instr[7], Instr[30:25],
                                     Instr[11:8], 1'b0}));
      T_U:    imm_c = XLEN'($signed({Instr[31:12], 12'b0}));
      T_J:    imm_c = XLEN'($signed({Instr[31], Instr[19:12], Instr[20],
                                     Instr[30:21], 1'b0}));
      T_Z:    imm_c = XLEN'(Instr[19:15]);
      T_SHAMT: begin
        if (XLEN == 64) begin
          imm_c = XLEN'(Instr[25:20]);
        end else begin
          // RV32 shifts only have 5 shamt bits; bit 25 set is malformed
          imm_c = XLEN'(Instr[24:20]);
          err_c = Instr[25];
        end
      end
      default: imm_c = '0;
    endcase
  end

  // Pack the decoded result with its echoes for capture
  always_comb begin
    new_c     = '0;
    new_c.imm = imm_c;
    new_c.err = err_c;
    new_c.typ = Imm_Type;
    new_c.tag = In_Tag;
  end

  assign accept_c = In_Valid && in_ready_q;
  assign drain_c  = main_valid_q && Out_Ready;

  // Next buffer state: flush wins, skid refills main, otherwise fill main then skid
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (Flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Input is blocked while skid holds an entry
      if (drain_c) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || drain_c) begin
      main_valid_d = accept_c;
      if (accept_c) begin
        main_d = new_c;
      end
    end else if (accept_c) begin
      skid_d       = new_c;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  // Buffer registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign In_Ready  = in_ready_q;
  assign Out_Valid = main_valid_q;
  assign Imm       = main_q.imm;
  assign Imm_Err   = main_q.err;
  assign Out_Type  = main_q.typ;
  assign Out_Tag   = main_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: checks imm_gen_pipe at XLEN=32 and XLEN=64 side by side
// against an arithmetic immediate model and a queue model of the buffer.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  imm_type;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        rdy32, vld32, err32;
  logic [31:0] imm32;
  logic [2:0]  typ32;
  logic [31:0] tag32;
  logic        rdy64, vld64, err64;
  logic [63:0] imm64;
  logic [2:0]  typ64;
  logic [31:0] tag64;

  imm_gen_pipe #(.XLEN(32), .INSTR_WIDTH(32), .TAG_WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .Flush(flush), .In_Valid(in_valid), .In_Ready(rdy32),
    .Instr(instr), .Imm_Type(imm_type), .In_Tag(in_tag), .Out_Valid(vld32),
    .Out_Ready(out_ready), .Imm(imm32), .Imm_Err(err32), .Out_Type(typ32), .Out_Tag(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .INSTR_WIDTH(32), .TAG_WIDTH(32)) u64 (
    .clk(clk), .rst_n(rst_n), .Flush(flush), .In_Valid(in_valid), .In_Ready(rdy64),
    .Instr(instr), .Imm_Type(imm_type), .In_Tag(in_tag), .Out_Valid(vld64),
    .Out_Ready(out_ready), .Imm(imm64), .Imm_Err(err64), .Out_Type(typ64), .Out_Tag(tag64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] i32;
    logic [63:0] i64;
    logic        e32;
    logic [2:0]  ty;
    logic [31:0] tg;
  } exp_t;

  exp_t mq[$];
  exp_t last;
  logic m_rdy;
  int   n_checks;
  int   n_fail;

  // Two's-complement value of an unsigned field of the given width
  function automatic longint sx(input longint f, input int bits);
    if (f >= (longint'(1) << (bits - 1))) return f - (longint'(1) << bits);
    return f;
  endfunction

  // Expected entry computed from the format rules with plain arithmetic
  function automatic exp_t ref_entry(input logic [31:0] ins, input logic [2:0] ty,
                                     input logic [31:0] tg);
    exp_t   e;
    longint v;
    logic [63:0] u;
    v = 0;
    e.e32 = 1'b0;
    case (ty)
      3'd1: v = sx(longint'(ins[31:20]), 12);
      3'd2: v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
      3'd3: v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                   longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
      3'd4: v = sx(longint'(ins[31:12]) * 4096, 32);
      3'd5: v = sx(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
                   longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
      3'd6: v = longint'(ins[19:15]);
      3'd7: v = longint'(ins[25:20]);
      default: v = 0;
    endcase
    u = 64'(v);
    e.i64 = u;
    e.i32 = u[31:0];
    if (ty == 3'd7) begin
      e.i32 = 32'(ins[24:20]);
      e.e32 = ins[25];
    end
    e.ty = ty;
    e.tg = tg;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] ty,
                       input logic [31:0] tg, input logic ordy, input logic fl);
    in_valid  = v;
    instr     = ins;
    imm_type  = ty;
    in_tag    = tg;
    out_ready = ordy;
    flush     = fl;
  endtask

  // One clock: advance the reference model at the edge, compare just after
  task automatic step();
    logic acc;
    logic pop;
    logic ev;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_rdy = 1'b0;
      last  = '{32'h0, 64'h0, 1'b0, 3'h0, 32'h0};
    end else if (flush) begin
      mq.delete();
      m_rdy = 1'b1;
    end else begin
      acc = in_valid && m_rdy;
      pop = (mq.size() > 0) && out_ready;
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(ref_entry(instr, imm_type, in_tag));
      m_rdy = (mq.size() < 2);
    end
    if (mq.size() > 0) last = mq[0];
    ev = (mq.size() > 0);
    #1;
    check("valid32", 64'(vld32), 64'(ev));
    check("ready32", 64'(rdy32), 64'(m_rdy));
    check("imm32",   64'(imm32), 64'(last.i32));
    check("err32",   64'(err32), 64'(last.e32));
    check("type32",  64'(typ32), 64'(last.ty));
    check("tag32",   64'(tag32), 64'(last.tg));
    check("valid64", 64'(vld64), 64'(ev));
    check("ready64", 64'(rdy64), 64'(m_rdy));
    check("imm64",   imm64,      last.i64);
    check("err64",   64'(err64), 64'h0);
    check("type64",  64'(typ64), 64'(last.ty));
    check("tag64",   64'(tag64), 64'(last.tg));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_rdy    = 1'b0;
    last     = '{32'h0, 64'h0, 1'b0, 3'h0, 32'h0};
    rst_n    = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);

    // Reset state
    step();
    step();
    check("rst_valid", 64'(vld32), 64'h0);
    check("rst_ready", 64'(rdy32), 64'h0);
    rst_n = 1'b1;
    step();
    check("rel_ready", 64'(rdy32), 64'h1);

    // Directed formats with the consumer always ready
    drive(1'b1, 32'hFFF00093, 3'd1, 32'h11, 1'b1, 1'b0); step();
    check("I_imm", 64'(imm32), 64'hFFFFFFFF);
    check("I_err", 64'(err32), 64'h0);
    drive(1'b1, 32'hFE000EE3, 3'd3, 32'h12, 1'b1, 1'b0); step();
    check("B_imm", 64'(imm32), 64'hFFFFFFFC);
    drive(1'b1, 32'h123450B7, 3'd4, 32'h13, 1'b1, 1'b0); step();
    check("U_imm32", 64'(imm32), 64'h12345000);
    check("U_imm64", imm64, 64'h12345000);
    drive(1'b1, 32'h800000B7, 3'd4, 32'h14, 1'b1, 1'b0); step();
    check("Uneg_imm32", 64'(imm32), 64'h80000000);
    check("Uneg_imm64", imm64, 64'hFFFFFFFF80000000);
    drive(1'b1, 32'h000F8000, 3'd6, 32'h15, 1'b1, 1'b0); step();
    check("Z_imm", 64'(imm32), 64'h1F);
    drive(1'b1, 32'h02100000, 3'd7, 32'h16, 1'b1, 1'b0); step();
    check("SH_imm64", imm64, 64'h21);
    check("SH_err64", 64'(err64), 64'h0);
    check("SH_imm32", 64'(imm32), 64'h01);
    check("SH_err32", 64'(err32), 64'h1);
    drive(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0); step();
    check("drained", 64'(vld32), 64'h0);

    // Backpressure: A to main, B to skid, C held until space opens
    drive(1'b1, 32'h00500093, 3'd1, 32'hA, 1'b0, 1'b0); step();
    check("bp_A_main", 64'(tag32), 64'hA);
    drive(1'b1, 32'h00600093, 3'd1, 32'hB, 1'b0, 1'b0); step();
    check("bp_ready_low", 64'(rdy32), 64'h0);
    drive(1'b1, 32'h00700093, 3'd1, 32'hC, 1'b0, 1'b0); step();
    check("bp_hold_A", 64'(tag32), 64'hA);
    step();
    check("bp_stable_imm", 64'(imm32), 64'h5);
    drive(1'b1, 32'h00700093, 3'd1, 32'hC, 1'b1, 1'b0); step();
    check("bp_out_B", 64'(tag32), 64'hB);
    check("bp_ready_up", 64'(rdy32), 64'h1);
    step();
    check("bp_out_C", 64'(tag32), 64'hC);
    drive(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0); step();
    check("bp_empty", 64'(vld32), 64'h0);

    // Flush with both entries full and a concurrent input
    drive(1'b1, 32'h00100093, 3'd1, 32'h21, 1'b0, 1'b0); step();
    drive(1'b1, 32'h00200093, 3'd1, 32'h22, 1'b0, 1'b0); step();
    drive(1'b1, 32'h00300093, 3'd1, 32'hF, 1'b0, 1'b1); step();
    check("fl_valid", 64'(vld32), 64'h0);
    check("fl_ready", 64'(rdy32), 64'h1);
    drive(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("fl_gone", 64'(vld32), 64'h0);
    end

    // Reset mid-stream with both entries full
    drive(1'b1, 32'h00100093, 3'd1, 32'h31, 1'b0, 1'b0); step();
    drive(1'b1, 32'h00200093, 3'd1, 32'h32, 1'b0, 1'b0); step();
    rst_n = 1'b0;
    step();
    check("mr_valid", 64'(vld32), 64'h0);
    check("mr_ready", 64'(rdy32), 64'h0);
    check("mr_imm",   imm64, 64'h0);
    check("mr_tag",   64'(tag32), 64'h0);
    rst_n = 1'b1;
    drive(1'b1, 32'hFFF00093, 3'd1, 32'h40, 1'b1, 1'b0); step();
    check("mr_rel_ready", 64'(rdy32), 64'h1);
    check("mr_rel_valid", 64'(vld32), 64'h0);
    step();
    check("mr_first_out", 64'(tag32), 64'h40);
    check("mr_first_v",   64'(vld32), 64'h1);

    // Randomised traffic with occasional flush and reset
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      drive(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
            $urandom, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
